ins_mem_loader: RTL and testbench

Write-side companion to the single-cycle CPU's byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes each one into the 256-byte instruction store as four big-endian bytes. Byte 0 at the word address holds bits 31:24, so the fetch side finds opcode bits 31:26 in `mem[pc][7:2]`. It sits between a program source (bench, UART, boot ROM) and the memory's byte write port, and replaces file preloading when a program must be loaded at run time.

---
 rtl/ins_mem_loader.sv | 166 ++++++++++++++++
 tb/tb_ins_mem_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_loader.sv
// Streams 32-bit instruction words into a byte-addressed instruction store.
// Each word is written as four big-endian bytes, so byte 0 of the word holds bits 31:24.
module ins_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_loaded
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Big-endian byte lane select: index 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [1:0]        state_q,        state_d;
    logic [ADDR_W-1:0] wr_ptr_q,       wr_ptr_d;
    logic [CNT_W-1:0]  remaining_q,    remaining_d;
    logic [CNT_W-1:0]  words_loaded_q, words_loaded_d;
    logic [31:0]       word_buf_q,     word_buf_d;
    logic [1:0]        byte_idx_q,     byte_idx_d;

    logic              in_ready_q,  in_ready_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    // Next-state logic for the load sequencer.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        remaining_d    = remaining_q;
        words_loaded_d = words_loaded_q;
        word_buf_d     = word_buf_q;
        byte_idx_d     = byte_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_loaded_d = {CNT_W{1'b0}};
                    if (word_count != {CNT_W{1'b0}}) begin
                        wr_ptr_d    = base_addr;
                        remaining_d = word_count;
                        state_d     = S_ACCEPT;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    word_buf_d = in_word;
                    byte_idx_d = 2'd0;
                    state_d    = S_WRITE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_WRITE: begin
                // The pointer wraps naturally at the top of the store.
                wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    words_loaded_d = words_loaded_q + CNT_W'(1);
                    remaining_d    = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without extra latency.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_ACCEPT);
        done_d     = (state_d == S_FINISH);
        mem_we_d   = (state_d == S_WRITE);
        if (mem_we_d) begin
            mem_addr_d  = wr_ptr_d;
            mem_wdata_d = be_byte(word_buf_d, byte_idx_d);
        end else begin
            mem_addr_d  = {ADDR_W{1'b0}};
            mem_wdata_d = 8'h00;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= {ADDR_W{1'b0}};
            remaining_q    <= {CNT_W{1'b0}};
            words_loaded_q <= {CNT_W{1'b0}};
            word_buf_q     <= 32'h0000_0000;
            byte_idx_q     <= 2'd0;
            in_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            mem_wdata_q    <= 8'h00;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            remaining_q    <= remaining_d;
            words_loaded_q <= words_loaded_d;
            word_buf_q     <= word_buf_d;
            byte_idx_q     <= byte_idx_d;
            in_ready_q     <= in_ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed self-checking bench for ins_mem_loader: one task per scenario.
module tb_ins_mem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [6:0] word_count;
    logic       in_valid;
    logic [31:0] in_word;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic [6:0] words_loaded;

    int errors = 0;
    int checks = 0;
    int we_count = 0;

    ins_mem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) we_count++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [7:0] base, input logic [6:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = 8'h00; word_count = 7'd0;
        in_valid = 1'b0; in_word = 32'h0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (words_loaded !== 7'd0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
    endtask

    task automatic test_single();
        logic [7:0] ea [4];
        logic [7:0] ed [4];
        ea = '{8'h00, 8'h01, 8'h02, 8'h03};
        ed = '{8'h8C, 8'h22, 8'h00, 8'h04};
        issue_start(8'h00, 7'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1; in_word = 32'h8C220004;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ea[b] || mem_wdata !== ed[b] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_byte%0d got we=%b %h@%h rdy=%b exp we=1 %h@%h rdy=0",
                         b, mem_we, mem_wdata, mem_addr, in_ready, ed[b], ea[b]);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL single_done got done=%b we=%b exp done=1 we=0", done, mem_we); end
        checks++; if (words_loaded !== 7'd1) begin errors++; $display("FAIL single_words got=%0d exp=1", words_loaded); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_multi_gaps();
        logic [31:0] words [3];
        int gaps [3];
        logic [7:0] addr;
        logic [7:0] exp_d;
        bit ok;
        words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        gaps  = '{0, 2, 5};
        addr  = 8'h10;
        issue_start(8'h10, 7'd3);
        for (int w = 0; w < 3; w++) begin
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (in_ready === 1'b1) begin ok = 1'b1; break; end
                tick();
            end
            checks++; if (!ok) begin errors++; $display("FAIL multi_wait_ready word%0d got ready=%b exp=1", w, in_ready); end
            for (int g = 0; g < gaps[w]; g++) tick();
            checks++; if (in_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL multi_gap word%0d got rdy=%b we=%b exp 1 0", w, in_ready, mem_we); end
            in_valid = 1'b1; in_word = words[w];
            tick();
            in_valid = 1'b0;
            for (int b = 0; b < 4; b++) begin
                exp_d = words[w][31-8*b -: 8];
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== addr || mem_wdata !== exp_d || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL multi_w%0d_b%0d got we=%b %h@%h rdy=%b exp we=1 %h@%h rdy=0",
                             w, b, mem_we, mem_wdata, mem_addr, in_ready, exp_d, addr);
                end
                addr = addr + 8'd1;
                tick();
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multi_done got=%b exp=1", done); end
        checks++; if (words_loaded !== 7'd3) begin errors++; $display("FAIL multi_words got=%0d exp=3", words_loaded); end
        tick();
        checks++; if (busy !== 1'b0 || words_loaded !== 7'd3) begin errors++; $display("FAIL multi_hold got busy=%b words=%0d exp 0 3", busy, words_loaded); end
    endtask

    task automatic test_wrap();
        logic [7:0] ea [4];
        logic [7:0] ed [4];
        ea = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        ed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        issue_start(8'hFE, 7'd1);
        in_valid = 1'b1; in_word = 32'hAABBCCDD;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ea[b] || mem_wdata !== ed[b]) begin
                errors++;
                $display("FAIL wrap_byte%0d got we=%b %h@%h exp we=1 %h@%h", b, mem_we, mem_wdata, mem_addr, ed[b], ea[b]);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || words_loaded !== 7'd1) begin errors++; $display("FAIL wrap_done got done=%b words=%0d exp 1 1", done, words_loaded); end
        tick();
    endtask

    task automatic test_zero_count();
        int we_before;
        we_before = we_count;
        issue_start(8'h33, 7'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_done got done=%b busy=%b exp 1 1", done, busy); end
        checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL zero_no_write got we=%b rdy=%b exp 0 0", mem_we, in_ready); end
        checks++; if (words_loaded !== 7'd0) begin errors++; $display("FAIL zero_words got=%0d exp=0", words_loaded); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_idle got busy=%b done=%b exp 0 0", busy, done); end
        checks++; if (we_count != we_before) begin errors++; $display("FAIL zero_we_count got=%0d exp=%0d", we_count, we_before); end
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] ea [8];
        logic [7:0] ed [8];
        ea = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
        ed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        issue_start(8'h40, 7'd2);
        in_valid = 1'b1; in_word = 32'h01020304;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ea[i] || mem_wdata !== ed[i] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignored_byte%0d got we=%b %h@%h rdy=%b exp we=1 %h@%h rdy=0",
                         i, mem_we, mem_wdata, mem_addr, in_ready, ed[i], ea[i]);
            end
            if (i == 1) begin
                start = 1'b1; base_addr = 8'h80; word_count = 7'd5;
                in_valid = 1'b1; in_word = 32'h05060708;
            end
            tick();
            start = 1'b0;
            if (i == 3) begin
                checks++; if (in_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ignored_reaccept got rdy=%b we=%b exp 1 0", in_ready, mem_we); end
                tick();
                in_valid = 1'b0;
            end
        end
        checks++; if (done !== 1'b1 || words_loaded !== 7'd2) begin errors++; $display("FAIL ignored_done got done=%b words=%0d exp 1 2", done, words_loaded); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid_load();
        int we_after;
        issue_start(8'h20, 7'd2);
        in_valid = 1'b1; in_word = 32'hCAFEF00D;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h21 || mem_wdata !== 8'hFE) begin errors++; $display("FAIL midrst_byte1 got we=%b %h@%h exp we=1 fe@21", mem_we, mem_wdata, mem_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        we_after = we_count;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin errors++; $display("FAIL midrst_mem got we=%b %h@%h exp 0 00@00", mem_we, mem_wdata, mem_addr); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b rdy=%b exp 0 0 0", busy, done, in_ready); end
        checks++; if (words_loaded !== 7'd0) begin errors++; $display("FAIL midrst_words got=%0d exp=0", words_loaded); end
        in_valid = 1'b1; in_word = 32'h12345678;
        for (int k = 0; k < 10; k++) tick();
        in_valid = 1'b0;
        checks++; if (we_count != we_after || busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet got writes=%0d busy=%b exp writes=%0d busy=0", we_count - we_after, busy, 0); end
        reset = 1'b1; start = 1'b1; base_addr = 8'h00; word_count = 7'd1;
        tick();
        reset = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL reset_beats_start got busy=%b rdy=%b exp 0 0", busy, in_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_gaps();
        test_wrap();
        test_zero_count();
        test_ignored_inputs();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
